// File: rtl/cam_pkg.sv
// Shared definitions for the camera capture front end: FSM states,
// pixel byte order and the frame-size helper used for the address bound.
package cam_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_VS,
    ST_CAPTURE,
    ST_DONE
  } cam_state_e;

  // First byte received for a pixel lands in the most significant byte.
  localparam bit MSB_FIRST = 1'b1;

  // Number of pixels actually stored per frame (with optional 2x2 decimation).
  function automatic int unsigned frame_pixels(input int unsigned h,
                                               input int unsigned v,
                                               input bit decim);
    return decim ? (h / 2) * (v / 2) : h * v;
  endfunction

endpackage

// File: rtl/cam_sync.sv
// N-stage synchroniser for an asynchronous sensor signal, with
// single-cycle rising/falling edge strobes in the clk domain.
module cam_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic sync_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sr_q;
  logic              prev_q;

  // Shift the raw input through the synchroniser chain and keep the last value for edge detect
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_q   <= '0;
      prev_q <= 1'b0;
    end else begin
      sr_q   <= {sr_q[STAGES-2:0], d_i};
      prev_q <= sr_q[STAGES-1];
    end
  end

  assign sync_o = sr_q[STAGES-1];
  assign rise_o = sr_q[STAGES-1] & ~prev_q;
  assign fall_o = ~sr_q[STAGES-1] & prev_q;

endmodule

// File: rtl/cam_capture_ctrl.sv
// Camera capture controller: XCLK generation, sensor signal sampling,
// pixel assembly, bounded frame-RAM writes and frame geometry checking.
// Optional build macro CAM_DECIM_EN: keep only even pixels of even lines.
module cam_capture_ctrl
  import cam_pkg::*;
#(
  parameter int unsigned XCLK_HALF     = 2,
  parameter int unsigned BYTES_PER_PIX = 2,
  parameter int unsigned H_RES         = 160,
  parameter int unsigned V_RES         = 120,
  parameter int unsigned ADDR_W        = 15,
  parameter int unsigned SYNC_STAGES   = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start_i,
  input  logic                         cont_i,
  output logic                         busy_o,
  output logic                         done_o,
  output logic                         err_o,
  output logic                         cam_xclk_o,
  input  logic                         cam_pclk_i,
  input  logic                         cam_vsync_i,
  input  logic                         cam_href_i,
  input  logic [7:0]                   cam_data_i,
  output logic                         mem_we_o,
  output logic [ADDR_W-1:0]            mem_adr_o,
  output logic [8*BYTES_PER_PIX-1:0]   mem_dat_o,
  output logic [ADDR_W-1:0]            line_cnt_o
);

`ifdef CAM_DECIM_EN
  localparam bit DECIM = 1'b1;
`else
  localparam bit DECIM = 1'b0;
`endif
  localparam int unsigned PW         = 8 * BYTES_PER_PIX;
  localparam int unsigned LINE_BYTES = H_RES * BYTES_PER_PIX;
  localparam int unsigned FRAME_PIX  = frame_pixels(H_RES, V_RES, DECIM);
  localparam int unsigned BC_W       = $clog2(LINE_BYTES + 2);
  localparam int unsigned XC_W       = $clog2(XCLK_HALF + 1);
  localparam int unsigned IDX_W      = ADDR_W + 1;

  cam_state_e state_q, state_d;

  logic [XC_W-1:0]   xcnt_q;
  logic              xclk_q;

  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [ADDR_W-1:0] line_q, line_d;
  logic [BC_W-1:0]   bcnt_q, bcnt_d;
  logic              phase_q, phase_d;
  logic [7:0]        hi_q, hi_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] adr_q, adr_d;
  logic [PW-1:0]     dat_q, dat_d;
  logic              err_q, err_d;
  logic              err_set;
`ifdef CAM_DECIM_EN
  logic              col_odd_q, col_odd_d;
`endif

  logic pclk_s, pclk_rise, pclk_fall;
  logic vs_s, vs_rise, vs_fall;
  logic href_s, href_rise, href_fall;
  logic unused_sync;

  logic          enter_cap;
  logic          byte_ev;
  logic          pix_done;
  logic          keep;
  logic [PW-1:0] pix_word;

  cam_sync #(.STAGES(SYNC_STAGES)) u_sync_pclk (
    .clk(clk), .rst(rst), .d_i(cam_pclk_i),
    .sync_o(pclk_s), .rise_o(pclk_rise), .fall_o(pclk_fall)
  );

  cam_sync #(.STAGES(SYNC_STAGES)) u_sync_vsync (
    .clk(clk), .rst(rst), .d_i(cam_vsync_i),
    .sync_o(vs_s), .rise_o(vs_rise), .fall_o(vs_fall)
  );

  cam_sync #(.STAGES(SYNC_STAGES)) u_sync_href (
    .clk(clk), .rst(rst), .d_i(cam_href_i),
    .sync_o(href_s), .rise_o(href_rise), .fall_o(href_fall)
  );

  assign unused_sync = &{1'b0, pclk_s, pclk_fall, vs_s, href_rise};

  // Free-running XCLK divider: toggles every XCLK_HALF clk cycles
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      xcnt_q <= '0;
      xclk_q <= 1'b0;
    end else if (xcnt_q == XC_W'(XCLK_HALF - 1)) begin
      xcnt_q <= '0;
      xclk_q <= ~xclk_q;
    end else begin
      xcnt_q <= xcnt_q + 1'b1;
    end
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // FSM next-state: arm on start, frame bounded by VSYNC falling/rising edges
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:    if (start_i) state_d = ST_WAIT_VS;
      ST_WAIT_VS: if (vs_fall) state_d = ST_CAPTURE;
      ST_CAPTURE: if (vs_rise) state_d = ST_DONE;
      ST_DONE:    state_d = cont_i ? ST_WAIT_VS : ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy_o = (state_q != ST_IDLE);
    done_o = (state_q == ST_DONE);
  end

  assign enter_cap = (state_q == ST_WAIT_VS) && vs_fall;
  assign byte_ev   = (state_q == ST_CAPTURE) && pclk_rise && href_s;
  assign pix_done  = (BYTES_PER_PIX == 1) ? 1'b1 : phase_q;

  if (BYTES_PER_PIX == 1) begin : g_word1
    assign pix_word = cam_data_i;
  end else begin : g_word2
    assign pix_word = MSB_FIRST ? {hi_q, cam_data_i} : {cam_data_i, hi_q};
  end

`ifdef CAM_DECIM_EN
  assign keep = ~col_odd_q & ~line_q[0];
`else
  assign keep = 1'b1;
`endif

  // Datapath next-state: byte assembly, bounded address generation, geometry checks
  always_comb begin
    idx_d   = idx_q;
    line_d  = line_q;
    bcnt_d  = bcnt_q;
    phase_d = phase_q;
    hi_d    = hi_q;
    we_d    = 1'b0;
    adr_d   = adr_q;
    dat_d   = dat_q;
    err_d   = err_q;
    err_set = 1'b0;
`ifdef CAM_DECIM_EN
    col_odd_d = col_odd_q;
`endif
    if (enter_cap) begin
      idx_d   = '0;
      line_d  = '0;
      bcnt_d  = '0;
      phase_d = 1'b0;
`ifdef CAM_DECIM_EN
      col_odd_d = 1'b0;
`endif
    end else if (state_q == ST_CAPTURE) begin
      if (byte_ev) begin
        if (bcnt_q != BC_W'(LINE_BYTES + 1)) bcnt_d = bcnt_q + 1'b1;
        if (!pix_done) begin
          hi_d    = cam_data_i;
          phase_d = 1'b1;
        end else begin
          phase_d = 1'b0;
`ifdef CAM_DECIM_EN
          col_odd_d = ~col_odd_q;
`endif
          if (keep) begin
            if (idx_q < IDX_W'(FRAME_PIX)) begin
              we_d  = 1'b1;
              adr_d = idx_q[ADDR_W-1:0];
              dat_d = pix_word;
              idx_d = idx_q + 1'b1;
            end else begin
              err_set = 1'b1;
            end
          end
        end
      end
      if (href_fall) begin
        line_d  = line_q + 1'b1;
        phase_d = 1'b0;
        bcnt_d  = '0;
`ifdef CAM_DECIM_EN
        col_odd_d = 1'b0;
`endif
        if (bcnt_q != BC_W'(LINE_BYTES)) err_set = 1'b1;
      end
      if (vs_rise && (line_q != ADDR_W'(V_RES))) err_set = 1'b1;
    end
    if ((state_q == ST_IDLE) && start_i) err_d = 1'b0;
    else if (err_set)                    err_d = 1'b1;
  end

  // Datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q   <= '0;
      line_q  <= '0;
      bcnt_q  <= '0;
      phase_q <= 1'b0;
      hi_q    <= '0;
      we_q    <= 1'b0;
      adr_q   <= '0;
      dat_q   <= '0;
      err_q   <= 1'b0;
`ifdef CAM_DECIM_EN
      col_odd_q <= 1'b0;
`endif
    end else begin
      idx_q   <= idx_d;
      line_q  <= line_d;
      bcnt_q  <= bcnt_d;
      phase_q <= phase_d;
      hi_q    <= hi_d;
      we_q    <= we_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      err_q   <= err_d;
`ifdef CAM_DECIM_EN
      col_odd_q <= col_odd_d;
`endif
    end
  end

  assign cam_xclk_o = xclk_q;
  assign mem_we_o   = we_q;
  assign mem_adr_o  = adr_q;
  assign mem_dat_o  = dat_q;
  assign err_o      = err_q;
  assign line_cnt_o = line_q;

endmodule

// File: tb/tb_cam_capture_ctrl.sv
// Self-checking bench for cam_capture_ctrl on a reduced 8x6x2B geometry.
// A sensor task emits frames; a frame-level model predicts the write
// stream and per-frame results, and one monitor compares every cycle.
module tb_cam_capture_ctrl;

  localparam int unsigned XH  = 2;
  localparam int unsigned BPP = 2;
  localparam int unsigned H   = 8;
  localparam int unsigned V   = 6;
  localparam int unsigned AW  = 6;
  localparam int unsigned SS  = 2;
  localparam int unsigned LB  = H * BPP;
`ifdef CAM_DECIM_EN
  localparam bit          DECIM = 1'b1;
  localparam int unsigned BOUND = (H / 2) * (V / 2);
`else
  localparam bit          DECIM = 1'b0;
  localparam int unsigned BOUND = H * V;
`endif

  logic               clk, rst, start_i, cont_i;
  logic               busy_o, done_o, err_o, cam_xclk_o;
  logic               cam_pclk_i, cam_vsync_i, cam_href_i;
  logic [7:0]         cam_data_i;
  logic               mem_we_o;
  logic [AW-1:0]      mem_adr_o;
  logic [8*BPP-1:0]   mem_dat_o;
  logic [AW-1:0]      line_cnt_o;

  cam_capture_ctrl #(
    .XCLK_HALF(XH), .BYTES_PER_PIX(BPP), .H_RES(H), .V_RES(V),
    .ADDR_W(AW), .SYNC_STAGES(SS)
  ) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .cont_i(cont_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .cam_xclk_o(cam_xclk_o),
    .cam_pclk_i(cam_pclk_i), .cam_vsync_i(cam_vsync_i), .cam_href_i(cam_href_i),
    .cam_data_i(cam_data_i), .mem_we_o(mem_we_o), .mem_adr_o(mem_adr_o),
    .mem_dat_o(mem_dat_o), .line_cnt_o(line_cnt_o)
  );

  typedef struct { int unsigned adr; logic [8*BPP-1:0] dat; } wr_t;
  typedef struct { bit err; int unsigned lines; int unsigned nwr; } fr_t;

  wr_t exp_q[$];
  fr_t exp_done[$];
  wr_t we_item;
  fr_t fr_item;

  int unsigned nchk, nerr;
  int unsigned done_cnt, frame_wr, wr_total;
  int unsigned first_adr;
  logic [8*BPP-1:0] first_dat;
  bit model_err;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every write must match the next predicted write; every done must match a predicted frame
  always @(negedge clk) begin
    if (rst) begin
      frame_wr = 0;
    end else begin
      if (mem_we_o === 1'b1) begin
        if (exp_q.size() == 0) begin
          nchk++; nerr++;
          $display("FAIL unexpected_write: got adr 0x%0h dat 0x%0h, expected no write", mem_adr_o, mem_dat_o);
        end else begin
          we_item = exp_q.pop_front();
          check("wr_adr", 32'(mem_adr_o), we_item.adr);
          check("wr_dat", 32'(mem_dat_o), 32'(we_item.dat));
        end
        if (wr_total == 0) begin
          first_adr = mem_adr_o;
          first_dat = mem_dat_o;
        end
        wr_total++;
        frame_wr++;
      end
      if (done_o === 1'b1) begin
        if (exp_done.size() == 0) begin
          nchk++; nerr++;
          $display("FAIL unexpected_done: got done_o=1, expected 0");
        end else begin
          fr_item = exp_done.pop_front();
          check("done_err", 32'(err_o), 32'(fr_item.err));
          check("done_line_cnt", 32'(line_cnt_o), fr_item.lines);
          check("done_frame_writes", frame_wr, fr_item.nwr);
          check("done_pending_writes", exp_q.size(), 0);
        end
        frame_wr = 0;
        done_cnt++;
      end
    end
  end

  task automatic drive_byte(input logic [7:0] b);
    @(negedge clk);
    cam_data_i = b; cam_pclk_i = 1'b0; cam_href_i = 1'b1;
    repeat (3) @(negedge clk);
    @(negedge clk);
    cam_pclk_i = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start_i = 1'b1;
    model_err = 1'b0;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  // Sensor + frame model. short_line: line sent 2 bytes short; abort_line/abort_byte: reset point
  task automatic send_frame(input int unsigned nlines, input int short_line,
                            input int abort_line, input int abort_byte, input bit fixed_first);
    int unsigned idx, nwr, nb, p;
    bit ferr, aborted, sel;
    logic [8*BPP-1:0] acc;
    logic [7:0] b;
    idx = 0; nwr = 0; ferr = 1'b0; aborted = 1'b0;
    repeat (4) @(negedge clk);
    cam_vsync_i = 1'b0;
    repeat (10) @(negedge clk);
    for (int unsigned l = 0; l < nlines; l++) begin
      nb  = (int'(l) == short_line) ? LB - 2 : LB;
      acc = '0;
      for (int unsigned by = 0; by < nb; by++) begin
        if (!aborted && int'(l) == abort_line && int'(by) == abort_byte) begin
          @(negedge clk);
          rst = 1'b1;
          #1;
          check("rst_we_immediate", 32'(mem_we_o), 0);
          check("rst_busy_immediate", 32'(busy_o), 0);
          @(negedge clk);
          check("rst_we_next", 32'(mem_we_o), 0);
          check("rst_line_cnt", 32'(line_cnt_o), 0);
          check("rst_pending_writes", exp_q.size(), 0);
          @(negedge clk);
          rst = 1'b0;
          aborted = 1'b1;
        end
        if (fixed_first && l == 0 && by < 2) b = (by == 0) ? 8'hAB : 8'hCD;
        else                                  b = 8'($urandom);
        acc = (acc << 8) | (8*BPP)'(b);
        if ((by % BPP) == BPP - 1) begin
          p   = by / BPP;
          sel = DECIM ? ((p % 2 == 0) && (l % 2 == 0)) : 1'b1;
          if (sel && !aborted) begin
            if (idx < BOUND) begin
              exp_q.push_back('{adr: idx, dat: acc});
              nwr++;
            end else begin
              ferr = 1'b1;
            end
            idx++;
          end
        end
        drive_byte(b);
      end
      @(negedge clk);
      cam_pclk_i = 1'b0; cam_href_i = 1'b0;
      if (nb != LB) ferr = 1'b1;
      repeat (11) @(negedge clk);
      if (int'(l) == short_line) check("err_after_short_line", 32'(err_o), 1);
    end
    if (nlines != V) ferr = 1'b1;
    @(negedge clk);
    cam_vsync_i = 1'b1;
    if (!aborted) begin
      model_err = model_err | ferr;
      exp_done.push_back('{err: model_err, lines: nlines, nwr: nwr});
    end
    repeat (20) @(negedge clk);
  endtask

  task automatic wait_done(input int unsigned target);
    for (int unsigned i = 0; i < 200 && done_cnt < target; i++) @(negedge clk);
    check("done_count", done_cnt, target);
  endtask

  logic xs[0:15];
  int unsigned xbad, wr_mark;

  initial begin
    nchk = 0; nerr = 0; done_cnt = 0; frame_wr = 0; wr_total = 0;
    first_adr = 32'hFFFF; first_dat = '0; model_err = 1'b0;
    rst = 1'b1; start_i = 1'b0; cont_i = 1'b0;
    cam_pclk_i = 1'b0; cam_vsync_i = 1'b1; cam_href_i = 1'b0; cam_data_i = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy_o), 0);
    check("rst_done", 32'(done_o), 0);
    check("rst_err", 32'(err_o), 0);
    check("rst_xclk", 32'(cam_xclk_o), 0);
    check("rst_we", 32'(mem_we_o), 0);
    check("rst_adr", 32'(mem_adr_o), 0);
    check("rst_dat", 32'(mem_dat_o), 0);
    check("rst_line_cnt", 32'(line_cnt_o), 0);
    rst = 1'b0;

    // XCLK period: level flips every XH cycles
    for (int unsigned i = 0; i < 16; i++) begin
      @(negedge clk);
      xs[i] = cam_xclk_o;
    end
    xbad = 0;
    for (int unsigned i = 0; i + 2*XH < 16; i++) begin
      if (xs[i] == xs[i+XH])   xbad++;
      if (xs[i] != xs[i+2*XH]) xbad++;
    end
    check("xclk_period_violations", xbad, 0);

    // Single normal frame, fixed first pixel
    pulse_start();
    check("busy_after_start", 32'(busy_o), 1);
    send_frame(V, -1, -1, -1, 1'b1);
    wait_done(1);
    check("busy_after_single", 32'(busy_o), 0);
    check("first_wr_adr", first_adr, 0);
    check("first_wr_dat", 32'(first_dat), 32'hABCD);
    check("frame_a_writes", wr_total, BOUND);

    // Short line -> error, frame still completes
    pulse_start();
    send_frame(V, 2, -1, -1, 1'b0);
    wait_done(2);
    check("err_sticky_after_b", 32'(err_o), 1);

    // Continuous mode across three frames; start clears error
    cont_i = 1'b1;
    pulse_start();
    check("err_cleared_by_start", 32'(err_o), 0);
    for (int unsigned f = 0; f < 3; f++) begin
      if (f == 2) cont_i = 1'b0;
      send_frame(V, -1, -1, -1, 1'b0);
      wait_done(3 + f);
      check("busy_cont", 32'(busy_o), (f < 2) ? 1 : 0);
    end

    // Extra line -> writes suppressed beyond bound, error
    pulse_start();
    wr_mark = wr_total;
    send_frame(V + 1, -1, -1, -1, 1'b0);
    wait_done(6);
    check("overflow_writes", wr_total - wr_mark, BOUND);
    check("overflow_err", 32'(err_o), 1);

    // Reset mid-line: no further writes, no done
    pulse_start();
    send_frame(V, -1, 2, 5, 1'b0);
    check("after_abort_busy", 32'(busy_o), 0);
    check("after_abort_done_count", done_cnt, 6);

    // Recovery frame
    pulse_start();
    send_frame(V, -1, -1, -1, 1'b0);
    wait_done(7);
    check("recovery_err", 32'(err_o), 0);

    check("leftover_writes", exp_q.size(), 0);
    check("leftover_frames", exp_done.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
